inst_loader: RTL

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/inst_loader.sv
// Serial instruction loader: assembles big-endian words from a byte stream and
// writes them sequentially into instruction memory until a halt word or memory full.
module inst_loader #(
    parameter int                 NB_DATA    = 32,
    parameter int                 NBYTE      = 8,
    parameter int                 N_ELEMENTS = 128,
    parameter int                 NB_ADDR    = 7,
    parameter logic [NB_DATA-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [NBYTE-1:0]   rx_data_i,
    input  logic               rx_done_i,
    output logic               en_write_o,
    output logic [NB_ADDR-1:0] addr_o,
    output logic [NB_DATA-1:0] data_o,
    output logic               busy_o,
    output logic               load_done_o,
    output logic [NB_ADDR:0]   words_o
);

    localparam int                 BYTES_PER_WORD = NB_DATA / NBYTE;
    localparam int                 CNT_W          = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0]   LAST_BYTE      = CNT_W'(BYTES_PER_WORD - 1);
    localparam logic [NB_ADDR-1:0] LAST_ADDR      = NB_ADDR'(N_ELEMENTS - 1);

    typedef enum logic [1:0] {IDLE, RECEIVE, WRITE, DONE} state_t;

    state_t             state_q, state_d;
    logic [NB_ADDR-1:0] addr_q;
    logic [NB_DATA-1:0] data_q;
    logic [NB_DATA-1:0] shift_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NB_ADDR:0]   words_q;

    logic [NB_DATA-1:0] shift_next;
    logic [NB_DATA-1:0] first_byte;
    logic               last_word;

    assign shift_next = {shift_q[NB_DATA-NBYTE-1:0], rx_data_i};
    assign first_byte = {{(NB_DATA-NBYTE){1'b0}}, rx_data_i};
    // The session ends on the halt marker or once the top address has been written.
    assign last_word  = (data_q == HALT_WORD) || (addr_q == LAST_ADDR);

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = RECEIVE;
            end
            RECEIVE: begin
                if (!start_i)                               state_d = IDLE;
                else if (rx_done_i && (cnt_q == LAST_BYTE)) state_d = WRITE;
            end
            WRITE: begin
                if (!start_i)      state_d = IDLE;
                else if (last_word) state_d = DONE;
                else               state_d = RECEIVE;
            end
            DONE: begin
                if (!start_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        en_write_o  = 1'b0;
        busy_o      = 1'b0;
        load_done_o = 1'b0;
        case (state_q)
            RECEIVE: busy_o = 1'b1;
            WRITE: begin
                busy_o     = 1'b1;
                en_write_o = 1'b1;
            end
            DONE:    load_done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            addr_q  <= '0;
            data_q  <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            words_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        addr_q  <= '0;
                        shift_q <= '0;
                        cnt_q   <= '0;
                        words_q <= '0;
                    end
                end
                RECEIVE: begin
                    if (start_i && rx_done_i) begin
                        if (cnt_q == LAST_BYTE) begin
                            data_q  <= shift_next;
                            shift_q <= '0;
                            cnt_q   <= '0;
                        end else begin
                            shift_q <= shift_next;
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                WRITE: begin
                    words_q <= words_q + (NB_ADDR+1)'(1);
                    // A byte arriving alongside the write starts the next word.
                    if (start_i && !last_word) begin
                        addr_q <= addr_q + NB_ADDR'(1);
                        if (rx_done_i) begin
                            shift_q <= first_byte;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign words_o = words_q;

endmodule
